// File: rtl/conversor_bcd.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per cycle,
// valid/ready on both sides; digits forced to F on values above LIMIT.
module conversor_bcd_dig (
  input  logic [3:0] d,
  output logic [3:0] a
);
  assign a = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module conversor_bcd #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] valor,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       milhar,
  output logic [3:0]       centena,
  output logic [3:0]       dezena,
  output logic [3:0]       unidade,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);
  // Enough BCD digits for 2^WIDTH-1 (log10(2) ~ 0.30103), never fewer than displayed.
  localparam int NDIG_RAW = (WIDTH * 30103) / 100000 + 1;
  localparam int NDIG     = (NDIG_RAW < 4) ? 4 : NDIG_RAW;
  localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0]         sreg, sreg_sh;
  logic [NDIG-1:0][3:0]     acc, adj, acc_sh;
  logic [CW-1:0]            cnt;
  logic                     ovf;
  logic                     last;

  assign last = (cnt == CW'(WIDTH - 1));

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    conversor_bcd_dig u_dig (.d(acc[i]), .a(adj[i]));
  end

  // The carry out of the top digit is dropped by the shift; it is always zero
  // because NDIG covers the full input range.
  always_comb {acc_sh, sreg_sh} = {adj, sreg} << 1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = SHIFT;
      SHIFT:   if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      overflow <= 1'b0;
      {milhar, centena, dezena, unidade} <= 16'h0000;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg <= valor;
          acc  <= '0;
          cnt  <= '0;
          ovf  <= (32'(valor) > LIMIT);
        end
        SHIFT: begin
          sreg <= sreg_sh;
          acc  <= acc_sh;
          cnt  <= cnt + 1'b1;
          // Result is latched on the final shift so it is ready on DONE entry.
          if (last) begin
            overflow <= ovf;
            {milhar, centena, dezena, unidade} <= ovf ? 16'hFFFF : acc_sh[3:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conversor_bcd.sv
// Directed bench for conversor_bcd: latency, boundaries, backpressure,
// input hold-off, mid-conversion reset and a strided sweep against div/mod.
module tb_conversor_bcd;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] valor;
  logic        in_valid, in_ready;
  logic [3:0]  milhar, centena, dezena, unidade;
  logic        overflow, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  conversor_bcd #(.WIDTH(16), .LIMIT(9999)) dut (
    .clk(clk), .rst_n(rst_n), .valor(valor), .in_valid(in_valid),
    .in_ready(in_ready), .milhar(milhar), .centena(centena), .dezena(dezena),
    .unidade(unidade), .overflow(overflow), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int v);
    if (v > 9999) return {1'b1, 16'hFFFF};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] res();
    return {overflow, milhar, centena, dezena, unidade};
  endfunction

  // One conversion; bp = cycles of out_ready=0 after out_valid is seen.
  task automatic conv(input int v, input int bp, input string tag);
    int n;
    bit rdy_seen;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_acc_rdy"}, 32'(in_ready), 1);
    valor = 16'(v); in_valid = 1'b1; out_ready = (bp == 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; valor = 16'($urandom);
    n = 1; rdy_seen = 1'b0;
    while (!out_valid && n < 40) begin
      rdy_seen |= in_ready;
      @(negedge clk); n++;
    end
    rdy_seen |= in_ready;
    chk({tag, "_lat"}, 32'(n), 17);
    chk({tag, "_rdy_busy"}, 32'(rdy_seen), 0);
    chk({tag, "_res"}, 32'(res()), 32'(model(v)));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, 32'(out_valid), 1);
      chk({tag, "_hold_res"}, 32'(res()), 32'(model(v)));
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({tag, "_post_vld"}, 32'(out_valid), 0);
    chk({tag, "_post_rdy"}, 32'(in_ready), 1);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; valor = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 1);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_res", 32'(res()), 0);
    rst_n = 1'b1;
    @(negedge clk);

    conv(1234, 0, "t1_1234");
    conv(0, 0, "t2_0");
    conv(9999, 0, "t2_9999");
    conv(10000, 0, "t2_10000");
    conv(65535, 0, "t2_65535");
    conv(507, 6, "t3_507");

    // in_valid held high; valor churns during SHIFT; second value waits for IDLE
    valor = 16'd1111; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    n = 1;
    seen = 1'b0;
    while (!out_valid && n < 40) begin
      valor = 16'($urandom); seen |= in_ready;
      @(negedge clk); n++;
    end
    chk("t4_rdy_busy", 32'(seen), 0);
    chk("t4_lat", 32'(n), 17);
    chk("t4_res1", 32'(res()), 32'(model(1111)));
    valor = 16'd2222; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t4_idle_rdy", 32'(in_ready), 1);
    chk("t4_idle_vld", 32'(out_valid), 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("t4_accept2", 32'(in_ready), 0);
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("t4_lat2", 32'(n), 17);
    chk("t4_res2", 32'(res()), 32'(model(2222)));
    @(posedge clk); @(negedge clk);

    // reset in the middle of a conversion
    valor = 16'd4321; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rdy", 32'(in_ready), 1);
    chk("t5_vld", 32'(out_valid), 0);
    chk("t5_res", 32'(res()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); seen |= out_valid; end
    chk("t5_no_vld", 32'(seen), 0);
    chk("t5_idle", 32'(in_ready), 1);

    // sweep: dense low range, both sides of LIMIT, strided rest, top end
    for (int v = 0; v < 1200; v++) conv(v, 0, "t6");
    for (int v = 9980; v < 10020; v++) conv(v, 0, "t6");
    for (int v = 1200; v < 65536; v += 97) conv(v, 0, "t6");
    for (int v = 65520; v < 65536; v++) conv(v, 0, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
